// File: rtl/adder_seq_ctrl.sv
`timescale 1ns/1ps
// Job sequencer for the ADDER partial-sum tree: issues N rounds paced by mul_rdy, then waits for psum.
// All outputs registered; synchronous active-low reset aborts any job silently.
module adder_seq_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cfg_wsize,
  input  logic             cfg_stride,
  input  logic             mul_rdy,
  input  logic             psum_valid,
  output logic             mul_pop,
  output logic             adder_valid,
  output logic [3:0]       adder_wsize,
  output logic             adder_stride,
  output logic [2:0]       adder_wround,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] jobs_done
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [1:0]        round_q, round_d, last_round;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              pop_q, pop_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [2:0]        wround_q, wround_d;
  logic [3:0]        wsize_q, wsize_d;
  logic              stride_q, stride_d;
  logic [CNT_W-1:0]  jobs_q, jobs_d;
  logic              cfg_ok;
  logic              last_issue;

  assign cfg_ok = (cfg_wsize <= 4'd2);

  // 3x3 -> 1 round, 5x5 -> 2 rounds, 7x7 -> 4 rounds
  always_comb begin
    case (wsize_q)
      4'd0:    last_round = 2'd0;
      4'd1:    last_round = 2'd1;
      default: last_round = 2'd3;
    endcase
  end

  assign last_issue = mul_rdy && (round_q == last_round);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && cfg_ok) state_d = S_ISSUE;
      S_ISSUE: if (last_issue) state_d = S_WAIT;
      S_WAIT:  if (psum_valid || (tcnt_q == TMO_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    valid_d  = 1'b0;
    pop_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wround_d = wround_q;
    wsize_d  = wsize_q;
    stride_d = stride_q;
    jobs_d   = jobs_q;
    round_d  = round_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            wsize_d  = cfg_wsize;
            stride_d = cfg_stride;
            round_d  = 2'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (mul_rdy) begin
          valid_d  = 1'b1;
          pop_d    = 1'b1;
          wround_d = {1'b0, round_q};
          round_d  = round_q + 2'd1;
          if (last_issue) tcnt_d = '0;
        end
      end
      S_WAIT: begin
        // completion takes priority over a coincident timeout
        if (psum_valid) begin
          done_d = 1'b1;
          jobs_d = jobs_q + CNT_W'(1);
        end else if (tcnt_q == TMO_LAST) begin
          err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      pop_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wround_q <= '0;
      wsize_q  <= '0;
      stride_q <= 1'b0;
      jobs_q   <= '0;
      round_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      pop_q    <= pop_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wround_q <= wround_d;
      wsize_q  <= wsize_d;
      stride_q <= stride_d;
      jobs_q   <= jobs_d;
      round_q  <= round_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign busy         = busy_q;
  assign adder_valid  = valid_q;
  assign mul_pop      = pop_q;
  assign done         = done_q;
  assign err          = err_q;
  assign adder_wround = wround_q;
  assign adder_wsize  = wsize_q;
  assign adder_stride = stride_q;
  assign jobs_done    = jobs_q;

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Job-level sequencer for the ADDER partial-sum tree.
- Accepts one convolution job (kernel size, stride) from the layer controller.
- Issues the per-round MUL_DATA_valid/wround sequence to ADDER, paced by multiplier-result availability, then waits for Psum_valid to retire the job.
- Sits between the layer controller, the multiplier array and ADDER. Reports done, timeout and illegal-configuration errors.

Parameters:
- TIMEOUT_CYC, 64, max cycles in WAIT_PSUM before the job is aborted with err.
- CNT_W, 16, width of the retired-job counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  job request; sampled in IDLE only.
- cfg_wsize  in  4  kernel code: 0=3x3, 1=5x5, 2=7x7, others illegal.
- cfg_stride  in  1  stride select, passed through to ADDER.
- mul_rdy  in  1  multiplier results for the current round are stable on MUL_results.
- psum_valid  in  1  Psum_valid from ADDER.
- mul_pop  out  1  one-cycle pulse: multiplier round consumed, advance to next round.
- adder_valid  out  1  drives ADDER MUL_DATA_valid.
- adder_wsize  out  4  drives ADDER wsize; latched per job.
- adder_stride  out  1  drives ADDER stride; latched per job.
- adder_wround  out  3  drives ADDER wround.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a job retires.
- err  out  1  one-cycle pulse on illegal cfg_wsize or timeout.
- jobs_done  out  CNT_W  count of retired jobs; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; every output 0; round counter, timeout counter and jobs_done cleared. Reset mid-job aborts with no done or err pulse.
- Round count: wsize 0 gives N=1, wsize 1 gives N=2, wsize 2 gives N=4. wround runs 0..N-1.
- All outputs are registered.
- States:
  - IDLE:
    - start=1 with cfg_wsize<=2: latch adder_wsize=cfg_wsize and adder_stride=cfg_stride; round=0; go to ISSUE.
    - start=1 with cfg_wsize>2: err=1 next cycle; stay IDLE; latched config unchanged.
  - ISSUE:
    - Each posedge with mul_rdy=1: next cycle adder_valid=1, adder_wround=round, mul_pop=1; round increments.
    - Posedge with mul_rdy=0: adder_valid=0, mul_pop=0, round held. These stall cycles are bubbles; ADDER sees valid low.
    - After issuing round N-1: go to WAIT_PSUM and clear the timeout counter.
    - Back-to-back mul_rdy gives N consecutive valid cycles with wround 0,1,...
  - WAIT_PSUM:
    - adder_valid=0.
    - psum_valid=1: done=1 and jobs_done+1 next cycle; go to IDLE.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYC-1 without psum_valid: err=1; go to IDLE; jobs_done unchanged.
    - psum_valid on the same posedge as the timeout: completion wins (done, no err).
- Entry latency: start sampled at edge t gives busy=1 in cycle t+1. The first adder_valid can appear at t+2 at the earliest (mul_rdy sampled at t+1).
- Exit timing: done and busy fall in the same cycle. A new start is accepted on the posedge after done, i.e. the cycle busy=0 is observed.
- start while busy: ignored, with no queueing and no err.
- psum_valid in IDLE or ISSUE: ignored; no counter change.
- adder_wsize and adder_stride hold their latched values through the end of the job and in IDLE afterwards. They change only on an accepted start or on reset.
- adder_wround holds its last issued value when adder_valid=0.
- jobs_done wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- 3x3 job: reset, start with wsize=0, stride=0, mul_rdy held 1, psum_valid 3 cycles after the last valid -> exactly one adder_valid cycle with wround=0, one mul_pop, done pulse, jobs_done=1, busy low after done.
- 7x7 job with stalls: wsize=2, mul_rdy pattern 1,0,1,1,0,1 -> adder_valid pattern 1,0,1,1,0,1 with wround 0,-,1,2,-,3; exactly 4 mul_pop pulses; WAIT_PSUM entered after wround=3.
- Illegal configuration: start with wsize=5 -> err pulse one cycle later, busy stays 0, no adder_valid, adder_wsize retains its previous value.
- Timeout and tie: 5x5 job with no psum_valid -> err exactly TIMEOUT_CYC cycles after WAIT_PSUM entry, jobs_done unchanged. Repeat with psum_valid on the timeout cycle -> done=1, err=0.
- Reset mid-job: assert rst_n=0 during round 1 of a 7x7 job -> next cycle every output is 0, no done or err; a following 3x3 job completes normally.
- Spurious inputs: start pulses while busy and psum_valid during ISSUE -> no effect. Two back-to-back 5x5 jobs -> jobs_done=2, second start accepted on the posedge after the first done.
